// File: rtl/mux_2to1_pkg.sv
// Shared definitions for the 2:1 multiplexer slice: select encodings and width limit.
package mux_pkg;

    localparam logic        MUX_SEL_A     = 1'b0;
    localparam logic        MUX_SEL_B     = 1'b1;
    localparam int unsigned MUX_MAX_WIDTH = 64;

endpackage

// File: rtl/mux_2to1_if.sv
// Data/select/enable bundle for mux_2to1; master drives inputs, slave produces y and y_q.
interface mux_2to1_if #(
    parameter int unsigned WIDTH = 1
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             en;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;

    modport master (
        output a, b, sel, en,
        input  y, y_q
    );

    modport slave (
        input  a, b, sel, en,
        output y, y_q
    );

endinterface

// File: rtl/mux_2to1_core.sv
// Per-bit combinational 2:1 select with no clock or reset dependence.
module mux_2to1_core
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // An unknown sel makes the condition X, so ?: merges a and b bitwise:
    // bits where a==b keep their value, the rest go X; synthesis sees a plain mux.
    assign y = (sel == MUX_SEL_A) ? a : b;

endmodule

// File: rtl/mux_2to1.sv
// 2:1 multiplexer: combinational output y plus an enabled, async-reset registered copy y_q.
module mux_2to1
    import mux_pkg::*;
#(
    parameter int unsigned                    WIDTH   = 1,
    parameter logic [MUX_MAX_WIDTH-1:0]       RST_VAL = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    mux_2to1_if.slave bus
);

    if (WIDTH < 1 || WIDTH > MUX_MAX_WIDTH) begin : g_bad_width
        $error("mux_2to1: WIDTH %0d outside 1..%0d", WIDTH, MUX_MAX_WIDTH);
    end

    localparam logic [WIDTH-1:0] RST_VAL_W = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] y_comb;
    logic [WIDTH-1:0] y_q;

    mux_2to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (bus.a),
        .b   (bus.b),
        .sel (bus.sel),
        .y   (y_comb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= RST_VAL_W;
        end else if (bus.en) begin
            y_q <= y_comb;
        end
    end

    assign bus.y   = y_comb;
    assign bus.y_q = y_q;

    a_sel_known: assert property (@(posedge clk)
        !$isunknown(bus.sel) |-> (y_comb == ((bus.sel == MUX_SEL_B) ? bus.b : bus.a)));

    a_rst_hold: assert property (@(posedge clk)
        !rst_n |-> (y_q == RST_VAL_W));

endmodule

// File: tb/tb_mux_2to1.sv
// Directed scoreboard bench for mux_2to1 at WIDTH=1 (RST_VAL 0 and 1) and WIDTH=8.
module tb_mux_2to1;

    typedef enum int unsigned {
        OBS_Y1, OBS_YQ1, OBS_YQ1R, OBS_Y8, OBS_YQ8, OBS_Y8_HI
    } obs_e;

    typedef struct {
        obs_e       id;
        logic [7:0] exp;
        string      name;
    } sb_item_t;

    logic clk;
    logic rst_n;

    mux_2to1_if #(.WIDTH(1)) if1  ();
    mux_2to1_if #(.WIDTH(1)) if1r ();
    mux_2to1_if #(.WIDTH(8)) if8  ();

    mux_2to1 #(.WIDTH(1), .RST_VAL(64'd0)) dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mux_2to1 #(.WIDTH(1), .RST_VAL(64'd1)) dut1r (.clk(clk), .rst_n(rst_n), .bus(if1r.slave));
    mux_2to1 #(.WIDTH(8), .RST_VAL(64'd0)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    sb_item_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    function automatic logic [7:0] observe(obs_e id);
        case (id)
            OBS_Y1:    return {7'd0, if1.y};
            OBS_YQ1:   return {7'd0, if1.y_q};
            OBS_YQ1R:  return {7'd0, if1r.y_q};
            OBS_Y8:    return if8.y;
            OBS_YQ8:   return if8.y_q;
            default:   return {4'd0, if8.y[7:4]};
        endcase
    endfunction

    task automatic expect_val(obs_e id, logic [7:0] exp, string name);
        sb_item_t it;
        it.id   = id;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    // Gives the monitor time to sample before stimulus moves on.
    task automatic settle();
        #2;
    endtask

    task automatic tick();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    // Monitor: pops expectations and compares against live DUT outputs.
    initial begin
        sb_item_t it;
        logic [7:0] act;
        forever begin
            wait (sb.size() != 0);
            #1;
            while (sb.size() != 0) begin
                it  = sb.pop_front();
                act = observe(it.id);
                n_checks++;
                if (act !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        clk   = 1'b0;
        rst_n = 1'b1;
        {if1.a, if1.b, if1.sel, if1.en}     = '0;
        {if1r.a, if1r.b, if1r.sel, if1r.en} = '0;
        {if8.a, if8.b, if8.sel, if8.en}     = '0;
        #1;
        rst_n = 1'b0;
        #2;

        // Reset state and combinational path under reset with no clock.
        if1.a = 1'b1; if1.b = 1'b0; if1.sel = 1'b0;
        #1;
        expect_val(OBS_YQ1,  8'h00, "rst_yq_rv0");
        expect_val(OBS_YQ1R, 8'h01, "rst_yq_rv1");
        expect_val(OBS_YQ8,  8'h00, "rst_yq_w8");
        expect_val(OBS_Y1,   8'h01, "y_under_reset");
        settle();

        // Truth table at WIDTH=1, still in reset.
        begin
            logic [2:0] vec [6] = '{3'b000, 3'b011, 3'b100, 3'b111, 3'b101, 3'b010};
            logic       res [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            for (int i = 0; i < 6; i++) begin
                {if1.a, if1.b, if1.sel} = vec[i];
                #8;
                expect_val(OBS_Y1, {7'd0, res[i]}, $sformatf("truth_%0d", i));
                settle();
            end
        end

        // Register path after reset release.
        #3;
        rst_n = 1'b1;
        #3;
        if1.en  = 1'b1; if1.a  = 1'b0; if1.b  = 1'b1; if1.sel  = 1'b1;
        if1r.en = 1'b1; if1r.a = 1'b0; if1r.b = 1'b1; if1r.sel = 1'b0;
        #2;
        tick();
        expect_val(OBS_YQ1,  8'h01, "yq_capture");
        expect_val(OBS_YQ1R, 8'h00, "yq_capture_rv1");
        settle();

        if1.en = 1'b0; if1.sel = 1'b0;
        #2;
        tick();
        expect_val(OBS_YQ1, 8'h01, "yq_hold_en0");
        expect_val(OBS_Y1,  8'h00, "y_while_hold");
        settle();

        // Asynchronous reset between edges.
        #1;
        rst_n = 1'b0;
        #1;
        expect_val(OBS_YQ1,  8'h00, "async_rst_rv0");
        expect_val(OBS_YQ1R, 8'h01, "async_rst_rv1");
        settle();
        #2;
        rst_n = 1'b1;
        #3;

        // Wide data at WIDTH=8.
        if8.a = 8'hA5; if8.b = 8'h3C; if8.sel = 1'b0; if8.en = 1'b0;
        #1;
        expect_val(OBS_Y8, 8'hA5, "w8_sel0");
        settle();
        if8.sel = 1'b1;
        #1;
        expect_val(OBS_Y8, 8'h3C, "w8_sel1");
        settle();
        if8.en = 1'b1;
        #2;
        tick();
        expect_val(OBS_YQ8, 8'h3C, "w8_yq_sel1");
        settle();
        if8.sel = 1'b0;
        #2;
        tick();
        expect_val(OBS_YQ8, 8'hA5, "w8_yq_sel0");
        settle();

        // Unknown select: bits where a==b must still resolve.
        if8.en = 1'b0;
        if8.a = 8'hF0; if8.b = 8'hFF; if8.sel = 1'bx;
        #1;
        expect_val(OBS_Y8_HI, 8'h0F, "xsel_upper_nibble");
        settle();
        if8.sel = 1'b0;

        begin
            int unsigned budget = 100;
            while (sb.size() != 0 && budget != 0) begin
                #1;
                budget--;
            end
            if (sb.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
            end
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_2to1.md
# mux_2to1

Two-input, one-select multiplexer with a combinational output and an optional registered copy. The combinational path `y` passes `a` or `b` straight through, as a glue-logic select on datapaths. The registered path `y_q` gives a timing-clean version of the same result for downstream synchronous logic. The block holds no other state.

## Interface
- `WIDTH`, default 1: data width of `a`, `b`, `y`, `y_q`; legal range 1..64.
- `RST_VAL`, default 0: value loaded into `y_q` while reset is asserted.
- `clk`: input, 1 bit. Single clock; `y_q` updates on the rising edge.
- `rst_n`: input, 1 bit. One clock; reset is asynchronous and active-low.
- `en`: input, 1 bit. Capture enable for `y_q`.
- `a`: input, WIDTH bits. Data input selected when `sel`=0.
- `b`: input, WIDTH bits. Data input selected when `sel`=1.
- `sel`: input, 1 bit. Select.
- `y`: output, WIDTH bits. Combinational mux result.
- `y_q`: output, WIDTH bits. Registered mux result.

## Operation
- `y = sel ? b : a`. This is purely combinational, with no dependence on `clk`, `rst_n` or `en`.
- `y` is valid whenever inputs are stable, including while `rst_n`=0 and before the first clock edge.
- `sel`=0 gives `y`=`a`; `sel`=1 gives `y`=`b`. The unselected input has no effect on `y`.
- `sel` X/Z in simulation:
  - Each bit of `y` where `a`==`b` equals that common value.
  - Every other bit is X.
  - The RTL is written so that synthesis infers a plain 2:1 mux per bit.
- `y_q`:
  - On a rising `clk` edge with `rst_n`=1 and `en`=1, `y_q` loads the current `y`.
  - With `en`=0, `y_q` holds its value.
- Reset:
  - `rst_n` falling forces `y_q` = `RST_VAL` immediately, without waiting for a clock edge.
  - `y_q` stays at `RST_VAL` while `rst_n`=0, regardless of `clk` or `en`.
  - Reset has no effect on `y`.
- Width: `RST_VAL` is truncated or zero-extended to WIDTH. No arithmetic is performed and no sign handling applies.

## Timing
- `y`: zero-cycle latency, one mux delay from `a`/`b`/`sel`. There is no combinational path from `clk` or `rst_n` to `y`.
- `y_q`: one-cycle latency. The value sampled at edge N appears after edge N and holds until the next enabled edge.
- Reset mid-operation: `y_q` goes to `RST_VAL` asynchronously.
- Reset release: `rst_n` deassertion must meet recovery/removal to `clk`, supplied by the codebase's reset synchroniser. The first capture happens on the first rising edge with `rst_n`=1 and `en`=1.
- Simultaneous `sel` change and clock edge: `y_q` captures the pre-edge value of `y`, per normal setup rules.
- No handshake; `en` is a level-sensitive qualifier.

## Structure
- Shared package `mux_pkg`:
  - `MUX_SEL_A` = 1'b0 and `MUX_SEL_B` = 1'b1 select encodings.
  - `MUX_MAX_WIDTH` = 64, used to check `WIDTH` at elaboration.
- Sub-module `mux_2to1_core`: the combinational per-bit mux, including the X-merge behaviour above.
- Top level `mux_2to1`:
  - instantiates the core;
  - adds the `y_q` register with asynchronous reset and enable;
  - holds the parameter checks;
  - holds assertions: `y` matches the selected input when `sel` is known; `y_q` equals `RST_VAL` while `rst_n`=0.

## Test plan
- Truth table, WIDTH=1, 10 time units per step. Required `y`:
  - a=0, b=0, sel=0 → 0
  - a=0, b=1, sel=1 → 1
  - a=1, b=0, sel=0 → 1
  - a=1, b=1, sel=1 → 1
  - a=1, b=0, sel=1 → 0
  - a=0, b=1, sel=0 → 0
- Combinational under reset: hold `rst_n`=0, drive a=1, b=0, sel=0 → `y`=1 with no clock running. `y_q`=`RST_VAL`.
- Register path: release reset, en=1, a=0, b=1, sel=1, one rising edge → `y_q`=1. Then set en=0 and sel=0 and clock again → `y_q` stays 1 while `y`=0.
- Asynchronous reset: with `y_q`=1, drop `rst_n` between clock edges → `y_q`=`RST_VAL` (0) immediately. Then drive `RST_VAL`=1 at WIDTH=1 and repeat the reset → `y_q`=1.
- Wide data, WIDTH=8: a=8'hA5, b=8'h3C. sel=0 → `y`=8'hA5; sel=1 → `y`=8'h3C. After an enabled edge, `y_q` equals `y`.
- X select: a=8'hF0, b=8'hFF, sel=X → `y` upper nibble = 4'hF and lower nibble = X.
